trace_checker: RTL and testbench
================================

# trace_checker

Consumer end of the spell-trace path. Takes the 16-bit trace published by the random trace generator over its `save_trace` level handshake. Plays the trace back cell-by-cell for display, then collects the player's drawn cells on the 4x4 grid. Grades the attempt and presents match/hit/miss results to game control.

## Interface
Parameters:
- `TIMEOUT_TICKS`, default 50: tick budget for player input in COLLECT (10 s at 5 Hz).
- `RESULT_TICKS`, default 10: ticks the result is held before returning to IDLE.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clk`-cycle enable pulse at 5 Hz, synchronous to `clk`.
- `trace`  in  16  trace from generator; bit k = grid cell k (row k/4, column k%4).
- `save_trace`  in  1  level; trace valid, held by producer until acknowledged.
- `trace_saved`  out  1  one-cycle ack pulse; producer releases `save_trace` on it.
- `show_valid`  out  1  playback active.
- `show_idx`  out  4  cell currently displayed.
- `show_bit`  out  1  trace value of `show_idx`.
- `cell_valid`  in  1  player touched a cell this cycle.
- `cell_idx`  in  4  touched cell index.
- `cell_done`  in  1  player finished drawing.
- `busy`  out  1  state != IDLE.
- `result_valid`  out  1  result outputs valid.
- `match`  out  1  drawn == trace.
- `hit_count`  out  5  popcount(drawn & trace), 0..16.
- `miss_count`  out  5  popcount(drawn & ~trace), 0..16.

## Operation
- States: IDLE, SHOW, COLLECT, RESULT.
- IDLE:
  - On `save_trace`=1, latch `trace` into `ref_q` and clear `drawn_q`.
  - Pulse `trace_saved` for exactly one cycle, then enter SHOW.
  - `save_trace` outside IDLE is ignored; there is no second ack.
- SHOW:
  - `show_idx` starts at 0 and advances by one per `tick`.
  - On the `tick` at `show_idx`=15, enter COLLECT with the timeout counter at 0.
- COLLECT:
  - `cell_valid` sets `drawn_q[cell_idx]`; repeated cells are idempotent.
  - The timeout counter increments per `tick`.
  - Exit to RESULT on `cell_done`, or on the tick that makes the counter equal `TIMEOUT_TICKS`.
  - `cell_valid` and `cell_done` in the same cycle: the cell is recorded and included in grading.
- RESULT:
  - `match`/`hit_count`/`miss_count` are registered from `ref_q`/`drawn_q` on entry.
  - Outputs are held while `result_valid`=1.
  - After `RESULT_TICKS` ticks, return to IDLE and drop `result_valid`.
- `cell_valid`/`cell_done` outside COLLECT: ignored.
- `trace` is sampled only on the capture cycle; later changes have no effect.

## Timing
- Reset values: state IDLE; `trace_saved`, `show_valid`, `result_valid`, `match` = 0; `show_idx`, `show_bit`, `hit_count`, `miss_count` = 0; `busy`=0; `ref_q`, `drawn_q`, counters = 0.
- Reset assertion mid-operation aborts immediately, with no ack or result.
- Capture: `save_trace` sampled high at edge N → `trace_saved`=1 and state SHOW after N, `trace_saved`=0 after N+1.
- `show_bit` is registered and changes on the same edge as `show_idx`.
- The result is visible on the edge following the COLLECT exit condition.
- `tick` coincident with a state transition is consumed by the old state only.

## Configuration
- `TRACE_CHECK_SHOW_EN` defined: SHOW state and `show_*` playback as above.
- Undefined:
  - Capture goes directly to COLLECT.
  - `show_valid`, `show_idx`, `show_bit` are tied to 0.
  - Ack timing is unchanged.

## Structure
- Package `trace_pkg` holds:
  - `TRACE_W`=16 and `GRID_DIM`=4.
  - State enum `trace_chk_state_t`.
  - Count width `CNT_W`=5.
- Sub-module `popcount16`: combinational 16-bit to 5-bit population count, instantiated twice (hits, misses).

## Test plan
- Reset mid-COLLECT with cells drawn → all outputs 0, state IDLE; next `save_trace` is acknowledged normally.
- `trace`=16'hF00F, `save_trace` held → one `trace_saved` pulse one cycle later. Playback `show_bit` sequence reads 1,1,1,1,0,…,0,1,1,1,1 over 16 ticks.
- Player enters cells 0–3 and 12–15, then `cell_done` → `match`=1, `hit_count`=8, `miss_count`=0.
- Player enters cells 0, 5, 5, 15, then `cell_done` in the same cycle as `cell_valid` for cell 14 → `match`=0, `hit_count`=3, `miss_count`=1.
- No input in COLLECT → RESULT after exactly 50 ticks with `hit_count`=0 and `match`=0, except `trace`=0, which yields `match`=1.
- `save_trace` toggled during SHOW/RESULT → no extra `trace_saved`; `ref_q` unchanged.

Source files
------------

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared constants and state type for the spell-trace checker.
//             TRACE_W  - trace width, one bit per cell of the 4x4 grid
//             GRID_DIM - grid edge length
//             CNT_W    - width of hit/miss counts (0..16)
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

    localparam int TRACE_W  = 16;
    localparam int GRID_DIM = 4;
    localparam int CNT_W    = 5;
    localparam int IDX_W    = $clog2(TRACE_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHOW    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_RESULT  = 2'd3
    } trace_chk_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : trace_checker_if
//  Purpose  : Bundles the trace handshake, player input, playback and result
//             signals of trace_checker.
//             master : environment side (generator, touch grid, game control)
//             slave  : trace_checker side
//  Revision : 1.0  initial release
// ============================================================================
interface trace_checker_if;
    import trace_pkg::*;

    // trace handshake
    logic [TRACE_W-1:0] trace;
    logic               save_trace;
    logic               trace_saved;
    // playback
    logic               show_valid;
    logic [IDX_W-1:0]   show_idx;
    logic               show_bit;
    // player input
    logic               cell_valid;
    logic [IDX_W-1:0]   cell_idx;
    logic               cell_done;
    // status / result
    logic               busy;
    logic               result_valid;
    logic               match;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   miss_count;

    modport master (
        output trace, save_trace, cell_valid, cell_idx, cell_done,
        input  trace_saved, show_valid, show_idx, show_bit,
        input  busy, result_valid, match, hit_count, miss_count
    );

    modport slave (
        input  trace, save_trace, cell_valid, cell_idx, cell_done,
        output trace_saved, show_valid, show_idx, show_bit,
        output busy, result_valid, match, hit_count, miss_count
    );

endinterface
`default_nettype wire

// File: rtl/popcount16.sv
`default_nettype none
// ============================================================================
//  Module   : popcount16
//  Purpose  : Combinational population count of a 16-bit vector.
//             i_data  - vector to count
//             o_count - number of set bits, 0..16
//  Revision : 1.0  initial release
// ============================================================================
module popcount16
    import trace_pkg::*;
(
    input  logic [TRACE_W-1:0] i_data,
    output logic [CNT_W-1:0]   o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < TRACE_W; i++) begin
            o_count = o_count + CNT_W'(i_data[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_checker.sv
`default_nettype none
// ============================================================================
//  Module   : trace_checker
//  Purpose  : Captures a 16-bit spell trace over the save_trace/trace_saved
//             handshake, optionally plays it back one cell per tick, collects
//             the player's drawn cells and grades the attempt.
//  Ports    : clk, rst_n (async, active-low), tick (5 Hz enable pulse),
//             bus (trace_checker_if.slave: handshake, playback, player input,
//             busy and match/hit_count/miss_count results)
//  Config   : TRACE_CHECK_SHOW_EN - when defined, the SHOW playback state is
//             built; otherwise capture goes straight to COLLECT and the
//             show_* outputs are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module trace_checker
    import trace_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 50,
    parameter int RESULT_TICKS  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    trace_checker_if.slave bus
);

    localparam int c_TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int c_RES_W = $clog2(RESULT_TICKS + 1);
    // Compare against "last" so the exit happens on the tick that would make
    // the counter reach the budget.
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [c_RES_W-1:0] c_RES_LAST = c_RES_W'(RESULT_TICKS - 1);

`ifdef TRACE_CHECK_SHOW_EN
    localparam trace_chk_state_t c_AFTER_CAPTURE = ST_SHOW;
    logic             r_show_valid;
    logic [IDX_W-1:0] r_show_idx;
    logic             r_show_bit;
`else
    localparam trace_chk_state_t c_AFTER_CAPTURE = ST_COLLECT;
`endif

    trace_chk_state_t   r_state;
    logic [TRACE_W-1:0] r_ref;
    logic [TRACE_W-1:0] r_drawn;
    logic [c_TMO_W-1:0] r_tmo;
    logic [c_RES_W-1:0] r_res_cnt;
    logic               r_trace_saved;
    logic               r_result_valid;
    logic               r_match;
    logic [CNT_W-1:0]   r_hit;
    logic [CNT_W-1:0]   r_miss;

    logic [TRACE_W-1:0] w_drawn_next;
    logic [CNT_W-1:0]   w_hit;
    logic [CNT_W-1:0]   w_miss;
    logic               w_collect_exit;

    // Grading uses the drawn set including this cycle's cell so that a cell
    // arriving together with cell_done is counted.
    always_comb begin
        w_drawn_next = r_drawn;
        if (bus.cell_valid) begin
            w_drawn_next[bus.cell_idx] = 1'b1;
        end
    end

    assign w_collect_exit = bus.cell_done | (tick & (r_tmo == c_TMO_LAST));

    popcount16 u_pop_hit (
        .i_data  (w_drawn_next & r_ref),
        .o_count (w_hit)
    );

    popcount16 u_pop_miss (
        .i_data  (w_drawn_next & ~r_ref),
        .o_count (w_miss)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ref          <= '0;
            r_drawn        <= '0;
            r_tmo          <= '0;
            r_res_cnt      <= '0;
            r_trace_saved  <= 1'b0;
            r_result_valid <= 1'b0;
            r_match        <= 1'b0;
            r_hit          <= '0;
            r_miss         <= '0;
`ifdef TRACE_CHECK_SHOW_EN
            r_show_valid   <= 1'b0;
            r_show_idx     <= '0;
            r_show_bit     <= 1'b0;
`endif
        end else begin
            r_trace_saved <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.save_trace) begin
                        r_ref         <= bus.trace;
                        r_drawn       <= '0;
                        r_tmo         <= '0;
                        r_trace_saved <= 1'b1;
                        r_state       <= c_AFTER_CAPTURE;
`ifdef TRACE_CHECK_SHOW_EN
                        r_show_valid  <= 1'b1;
                        r_show_idx    <= '0;
                        r_show_bit    <= bus.trace[0];
`endif
                    end
                end
`ifdef TRACE_CHECK_SHOW_EN
                ST_SHOW: begin
                    if (tick) begin
                        if (r_show_idx == IDX_W'(TRACE_W - 1)) begin
                            r_show_valid <= 1'b0;
                            r_show_idx   <= '0;
                            r_show_bit   <= 1'b0;
                            r_tmo        <= '0;
                            r_state      <= ST_COLLECT;
                        end else begin
                            r_show_idx <= r_show_idx + 1'b1;
                            r_show_bit <= r_ref[r_show_idx + 1'b1];
                        end
                    end
                end
`endif
                ST_COLLECT: begin
                    r_drawn <= w_drawn_next;
                    if (tick) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                    if (w_collect_exit) begin
                        r_match        <= (w_drawn_next == r_ref);
                        r_hit          <= w_hit;
                        r_miss         <= w_miss;
                        r_result_valid <= 1'b1;
                        r_res_cnt      <= '0;
                        r_state        <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (tick) begin
                        if (r_res_cnt == c_RES_LAST) begin
                            r_result_valid <= 1'b0;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_res_cnt <= r_res_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.trace_saved  = r_trace_saved;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.result_valid = r_result_valid;
    assign bus.match        = r_match;
    assign bus.hit_count    = r_hit;
    assign bus.miss_count   = r_miss;

`ifdef TRACE_CHECK_SHOW_EN
    assign bus.show_valid = r_show_valid;
    assign bus.show_idx   = r_show_idx;
    assign bus.show_bit   = r_show_bit;
`else
    assign bus.show_valid = 1'b0;
    assign bus.show_idx   = '0;
    assign bus.show_bit   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_checker
//  Purpose  : Self-checking bench for trace_checker. Directed scenarios plus
//             randomized attempts, graded against a set-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trace_checker;
    import trace_pkg::*;

    localparam int TMO = 50;
    localparam int RES = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acks   = 0;
    int exp_acks = 0;
    int cells_q[$];

    always #5 clk = ~clk;

    trace_checker_if u_if ();

    trace_checker #(
        .TIMEOUT_TICKS (TMO),
        .RESULT_TICKS  (RES)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .bus   (u_if)
    );

    always @(negedge clk) begin
        if (u_if.trace_saved === 1'b1) n_acks++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},   32'(u_if.busy), 0);
        check({tag, "_ack"},    32'(u_if.trace_saved), 0);
        check({tag, "_rvalid"}, 32'(u_if.result_valid), 0);
        check({tag, "_match"},  32'(u_if.match), 0);
        check({tag, "_hit"},    32'(u_if.hit_count), 0);
        check({tag, "_miss"},   32'(u_if.miss_count), 0);
        check({tag, "_show"},   32'({u_if.show_valid, u_if.show_idx, u_if.show_bit}), 0);
    endtask

    task automatic capture(input logic [15:0] t, input int hold);
        u_if.trace      = t;
        u_if.save_trace = 1'b1;
        cyc();
        check("ack_pulse", 32'(u_if.trace_saved), 1);
        check("busy_cap",  32'(u_if.busy), 1);
        for (int i = 0; i < hold; i++) cyc();
        u_if.save_trace = 1'b0;
        u_if.trace      = 16'($urandom);   // later changes must not matter
        cyc();
        check("ack_drop", 32'(u_if.trace_saved), 0);
        exp_acks++;
    endtask

    task automatic show_phase(input logic [15:0] r);
`ifdef TRACE_CHECK_SHOW_EN
        for (int k = 0; k < TRACE_W; k++) begin
            check("show_valid", 32'(u_if.show_valid), 1);
            check("show_idx",   32'(u_if.show_idx), 32'(k));
            check("show_bit",   32'(u_if.show_bit), 32'(r[k]));
            // inputs that must be ignored during playback
            u_if.cell_valid = 1'b1;
            u_if.cell_idx   = 4'($urandom);
            u_if.save_trace = 1'b1;
            cyc();
            u_if.cell_valid = 1'b0;
            u_if.save_trace = 1'b0;
            tick_cyc();
        end
        check("show_end", 32'(u_if.show_valid), 0);
`else
        check("show_tied", 32'({u_if.show_valid, u_if.show_idx, u_if.show_bit, r[0] & 1'b0}), 0);
`endif
    endtask

    task automatic result_phase(input logic m, input int h, input int mi);
        for (int i = 1; i <= RES; i++) begin
            u_if.save_trace = (i % 2 == 0);
            u_if.cell_valid = 1'b1;
            u_if.cell_idx   = 4'($urandom);
            tick_cyc();
            u_if.save_trace = 1'b0;
            u_if.cell_valid = 1'b0;
            if (i == RES - 1) begin
                check("res_hold_valid", 32'(u_if.result_valid), 1);
                check("res_hold", 32'({u_if.match, u_if.hit_count, u_if.miss_count}),
                      32'({m, 5'(h), 5'(mi)}));
            end
        end
        check("res_drop",  32'(u_if.result_valid), 0);
        check("res_idle",  32'(u_if.busy), 0);
        cyc();
        check("ack_count", 32'(n_acks), 32'(exp_acks));
    endtask

    // Plays cells_q; the last cell optionally coincides with cell_done.
    task automatic collect_and_grade(input logic [15:0] r, input bit done_with_last);
        logic [15:0] drawn;
        logic [3:0]  c;
        int          ticks;
        int          n;
        logic        e_match;
        int          e_hit;
        int          e_miss;
        drawn = '0;
        ticks = 0;
        n     = cells_q.size();
        for (int k = 0; k < n; k++) begin
            c        = 4'(cells_q[k]);
            drawn[c] = 1'b1;
            u_if.cell_valid = 1'b1;
            u_if.cell_idx   = c;
            if (done_with_last && k == n - 1) u_if.cell_done = 1'b1;
            else if ($urandom_range(0, 3) == 0 && ticks < TMO - 5) begin
                tick = 1'b1;
                ticks++;
            end
            cyc();
            u_if.cell_valid = 1'b0;
            u_if.cell_done  = 1'b0;
            tick            = 1'b0;
            if (!(done_with_last && k == n - 1))
                check("no_early_res", 32'(u_if.result_valid), 0);
        end
        if (!done_with_last) begin
            u_if.cell_done = 1'b1;
            cyc();
            u_if.cell_done = 1'b0;
        end
        e_match = (drawn == r);
        e_hit   = $countones(drawn & r);
        e_miss  = $countones(drawn & ~r);
        check("res_valid", 32'(u_if.result_valid), 1);
        check("res_match", 32'(u_if.match), 32'(e_match));
        check("res_hit",   32'(u_if.hit_count), 32'(e_hit));
        check("res_miss",  32'(u_if.miss_count), 32'(e_miss));
        result_phase(e_match, e_hit, e_miss);
    endtask

    task automatic timeout_run(input logic [15:0] r);
        capture(r, 0);
        show_phase(r);
        for (int i = 1; i <= TMO; i++) begin
            tick_cyc();
            if (i == TMO - 1) check("tmo_early", 32'(u_if.result_valid), 0);
            cyc();
        end
        check("tmo_valid", 32'(u_if.result_valid), 1);
        check("tmo_match", 32'(u_if.match), 32'(r == 16'h0000));
        check("tmo_hit",   32'(u_if.hit_count), 0);
        check("tmo_miss",  32'(u_if.miss_count), 0);
        result_phase(r == 16'h0000, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        u_if.trace      = '0;
        u_if.save_trace = 1'b0;
        u_if.cell_valid = 1'b0;
        u_if.cell_idx   = '0;
        u_if.cell_done  = 1'b0;
        cyc();
        cyc();
        check_idle_zero("reset");
        rst_n = 1'b1;
        cyc();

        // full match, save_trace held for several cycles
        r = 16'hF00F;
        capture(r, 3);
        show_phase(r);
        cells_q = {0, 1, 2, 3, 12, 13, 14, 15};
        collect_and_grade(r, 1'b0);

        // repeated cell, done coincident with last cell
        capture(r, 0);
        show_phase(r);
        cells_q = {0, 5, 5, 15, 14};
        collect_and_grade(r, 1'b1);

        // timeout with and without an empty trace
        timeout_run(16'($urandom) | 16'h0100);
        timeout_run(16'h0000);

        // reset in the middle of COLLECT
        r = 16'h1234;
        capture(r, 0);
        show_phase(r);
        u_if.cell_valid = 1'b1;
        u_if.cell_idx   = 4'd2;
        cyc();
        u_if.cell_idx   = 4'd4;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrst");
        u_if.cell_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check_idle_zero("postrst");

        // randomized attempts
        for (int t = 0; t < 8; t++) begin
            r = 16'($urandom);
            capture(r, int'($urandom_range(0, 2)));
            show_phase(r);
            cells_q = {};
            for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
                if ($urandom_range(0, 1) == 0) cells_q.push_back(int'($urandom_range(0, 15)));
                else begin
                    // bias toward cells that are in the trace
                    for (int b = 0; b < 16; b++) begin
                        if (r[(b + k) % 16]) begin
                            cells_q.push_back((b + k) % 16);
                            break;
                        end
                    end
                end
            end
            if (cells_q.size() == 0) cells_q.push_back(3);
            collect_and_grade(r, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
